// File: rtl/ce_stream_reader.sv
// ce-strobed write buffer: captures words on ce into a small circular FIFO and
// drains them over valid/ready. Define CE_OVF_COUNT_EN to add the ovf_cnt port.
module ce_stream_reader #(
  parameter int n     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     ce,
  input  logic [n-1:0]             D,
  output logic                     valid,
  input  logic                     ready,
  output logic [n-1:0]             Q,
  output logic [$clog2(DEPTH):0]   count,
`ifdef CE_OVF_COUNT_EN
  output logic                     overflow,
  output logic [7:0]               ovf_cnt
`else
  output logic                     overflow
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;

  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [n-1:0]  entry_data [DEPTH];

  assign full  = (count_reg == FULL_COUNT);
  assign valid = (count_reg != '0);
  // A pop frees the head slot in the same edge, so a full buffer still accepts ce.
  assign pop   = valid & ready & ~clr;
  assign push  = ce & ~clr & (~full | pop);
  assign drop  = ce & ~clr & full & ~pop;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [n-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PW'(gi))) begin
          entry_reg <= D;
        end
      end
      assign entry_data[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg    <= count_reg + CW'(push) - CW'(pop);
      overflow_reg <= drop;
    end
  end

  // Stale RAM contents never leak: the head is masked whenever the buffer is empty.
  assign Q        = valid ? entry_data[rd_ptr_reg] : '0;
  assign count    = count_reg;
  assign overflow = overflow_reg;

`ifdef CE_OVF_COUNT_EN
  logic [7:0] ovf_cnt_reg;

  // Survives clr on purpose; only rst forgets how many words were lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_cnt_reg <= '0;
    end else if (drop && (ovf_cnt_reg != 8'hFF)) begin
      ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_reg;
`endif

endmodule
